conv_out_maxpool_2x2: RTL

- Receiving end of the conv core output stream (OUT/VALID/LAST_IN_LINE/LAST_PIX).
- Performs 2x2 stride-2 max pooling on the P_WIDTH x P_HEIGHT ReLU'd feature map and emits a P_WIDTH/2 x P_HEIGHT/2 stream with the same framing.
- LAST_PIX_OUT feeds the upstream core's NEXT_LAST_PIX so its SQUEEZE_OUT clears once this layer has finished.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/pool_line_buf.sv | 26 ++
 rtl/conv_out_maxpool_2x2.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output-stage blocks: row-phase state
// encodings and an unsigned max helper.
package cnn_pkg;

  // Widest pixel the max helper handles; callers zero-extend into it.
  localparam int CNN_MAX_DW = 64;

  // Row phase of the 2x2 pooling window.
  typedef enum logic {
    S_ROW_EVEN = 1'b0,
    S_ROW_ODD  = 1'b1
  } row_state_e;

  // Unsigned max; inputs are post-ReLU so no sign handling is wanted.
  function automatic logic [CNN_MAX_DW-1:0] max_u(input logic [CNN_MAX_DW-1:0] a,
                                                  input logic [CNN_MAX_DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-line buffer holding the horizontal pair maxima of the even row.
// Read is combinational; a block-RAM version would need the read issued
// one beat earlier (on the even-column beat).
module pool_line_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 24
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port; contents are never reset since each even row refills them.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_out_maxpool_2x2.sv
// 2x2 stride-2 max pooling on the conv core output stream. Even rows store
// pair maxima in a half-line buffer; odd rows combine them with the current
// pair and emit one pooled pixel per two input columns, with framing flags.
module conv_out_maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int P_WIDTH  = 64,
  parameter int P_HEIGHT = 64,
  parameter int P_WCNT_W = 6,
  parameter int P_HCNT_W = 6,
  parameter int DW       = 24
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          DIN_VALID,
  input  logic [DW-1:0] DIN,
  input  logic          DIN_LAST_IN_LINE,
  input  logic          DIN_LAST_PIX,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_VALID,
  output logic          DOUT_LAST_IN_LINE,
  output logic          DOUT_LAST_PIX,
  output logic          LAST_PIX_OUT,
  output logic          ERR
);

  localparam int AW = P_WCNT_W - 1;

  row_state_e            state_reg, state_next;
  logic [P_WCNT_W-1:0]   h_cnt_reg, h_cnt_next;
  logic [P_HCNT_W-1:0]   v_cnt_reg, v_cnt_next;
  logic [DW-1:0]         hold_reg;
  logic [DW-1:0]         dout_reg;
  logic                  dout_valid_reg, dout_lil_reg, dout_lp_reg, err_reg;

  logic                  last_col, last_row, odd_col, line_end, framing_bad;
  logic                  lb_we, pool_fire;
  logic [DW-1:0]         pair_max, quad_max, lb_rdata;

  assign last_col = (h_cnt_reg == P_WCNT_W'(P_WIDTH - 1));
  assign last_row = (v_cnt_reg == P_HCNT_W'(P_HEIGHT - 1));
  assign odd_col  = h_cnt_reg[0];
  // A flagged line end resyncs early; a missing flag is ignored and the
  // column counter still closes the line on its own.
  assign line_end = DIN_LAST_IN_LINE || last_col;
  assign framing_bad = (DIN_LAST_IN_LINE != last_col) ||
                       (DIN_LAST_PIX != (last_col && last_row));

  assign pair_max = DW'(max_u(CNN_MAX_DW'(hold_reg), CNN_MAX_DW'(DIN)));
  assign quad_max = DW'(max_u(CNN_MAX_DW'(pair_max), CNN_MAX_DW'(lb_rdata)));

  pool_line_buf #(
    .DEPTH (P_WIDTH / 2),
    .AW    (AW),
    .DW    (DW)
  ) u_line_buf (
    .CLK   (CLK),
    .we    (lb_we),
    .waddr (h_cnt_reg[P_WCNT_W-1:1]),
    .wdata (pair_max),
    .raddr (h_cnt_reg[P_WCNT_W-1:1]),
    .rdata (lb_rdata)
  );

  // Row-phase state register.
  always_ff @(posedge CLK) begin
    if (!RSTn) state_reg <= S_ROW_EVEN;
    else       state_reg <= state_next;
  end

  // Next row phase: toggles at each line end, frame end forces the even row.
  always_comb begin
    state_next = state_reg;
    if (DIN_VALID) begin
      if (DIN_LAST_PIX) begin
        state_next = S_ROW_EVEN;
      end else if (line_end) begin
        if (last_row)                     state_next = S_ROW_EVEN;
        else if (state_reg == S_ROW_EVEN) state_next = S_ROW_ODD;
        else                              state_next = S_ROW_EVEN;
      end
    end
  end

  // Phase-dependent actions on odd-column beats: store or emit.
  always_comb begin
    lb_we     = 1'b0;
    pool_fire = 1'b0;
    if (DIN_VALID && odd_col) begin
      if (state_reg == S_ROW_EVEN) lb_we     = 1'b1;
      else                         pool_fire = 1'b1;
    end
  end

  // Column/row counter successors, including resync on upstream flags.
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (DIN_VALID) begin
      if (DIN_LAST_PIX) begin
        h_cnt_next = '0;
        v_cnt_next = '0;
      end else if (line_end) begin
        h_cnt_next = '0;
        v_cnt_next = last_row ? '0 : v_cnt_reg + P_HCNT_W'(1);
      end else begin
        h_cnt_next = h_cnt_reg + P_WCNT_W'(1);
      end
    end
  end

  // Counters, even-column hold register and sticky framing error.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      hold_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
      if (DIN_VALID && !odd_col) hold_reg <= DIN;
      if (DIN_VALID && framing_bad) err_reg <= 1'b1;
    end
  end

  // Output register: pooled pixel plus framing, one cycle after the beat.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      dout_lil_reg   <= 1'b0;
      dout_lp_reg    <= 1'b0;
    end else begin
      dout_valid_reg <= pool_fire;
      dout_lil_reg   <= pool_fire && last_col;
      dout_lp_reg    <= pool_fire && last_col && last_row;
      if (pool_fire) dout_reg <= quad_max;
    end
  end

  assign DOUT              = dout_reg;
  assign DOUT_VALID        = dout_valid_reg;
  assign DOUT_LAST_IN_LINE = dout_lil_reg;
  assign DOUT_LAST_PIX     = dout_lp_reg;
  assign LAST_PIX_OUT      = dout_lp_reg;
  assign ERR               = err_reg;

endmodule
